// File: rtl/qed_pkg.sv
// qed_pkg: shared definitions for the QED replay buffer.
//   QED_NOP      - canonical RISC-V NOP (addi x0,x0,0) driven when no replay is valid
//   qed_state_e  - CAPTURE / REPLAY phase encoding
//   count_width  - width of an occupancy counter that can hold 0..depth
package qed_pkg;

  localparam logic [31:0] QED_NOP = 32'h0000_0013;

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_REPLAY  = 1'b1
  } qed_state_e;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/qed_replay_buffer_if.sv
// qed_replay_buffer_if: bundle of the control, fetch and replay signals of the
// QED replay buffer.
//   master - the driving side (IFU / pipeline control): drives ena, exec_dup,
//            stall_IF, ifu_vld, ifu_instruction, flush; observes status.
//   slave  - the replay buffer itself.
interface qed_replay_buffer_if #(
  parameter int INSN_W = 32,
  parameter int DEPTH  = 16
);
  import qed_pkg::*;

  localparam int CNT_W = count_width(DEPTH);

  logic              ena;
  logic              exec_dup;
  logic              stall_IF;
  logic              ifu_vld;
  logic [INSN_W-1:0] ifu_instruction;
  logic              flush;
  logic [INSN_W-1:0] rpl_instruction;
  logic              vld_out;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              dup_done;
  logic              overflow_err;
  logic              underrun_err;

  modport master (
    output ena, exec_dup, stall_IF, ifu_vld, ifu_instruction, flush,
    input  rpl_instruction, vld_out, full, empty, count,
           dup_done, overflow_err, underrun_err
  );

  modport slave (
    input  ena, exec_dup, stall_IF, ifu_vld, ifu_instruction, flush,
    output rpl_instruction, vld_out, full, empty, count,
           dup_done, overflow_err, underrun_err
  );

endinterface

// File: rtl/qed_replay_mem.sv
// qed_replay_mem: DEPTH x INSN_W storage, one write port and one registered
// read port. Contents are never reset; the read register only updates when
// rd_en is high so the last read word is held otherwise.
//   clk      - clock
//   wr_en    - write mem[wr_addr] <= wr_data
//   rd_en    - load rd_data <= mem[rd_addr]
//   rd_data  - registered read data
module qed_replay_mem #(
  parameter int INSN_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [INSN_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [INSN_W-1:0] rd_data
);

  logic [INSN_W-1:0] mem_q [DEPTH];
  logic [INSN_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/qed_replay_buffer.sv
// qed_replay_buffer: circular buffer between the IFU fetch output and the QED
// decoder. While exec_dup=0 fetched originals are captured; while exec_dup=1
// they are replayed in order, one per unstalled cycle, with 1-cycle latency.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - qed_replay_buffer_if slave: control inputs (ena, exec_dup,
//              stall_IF, ifu_vld, ifu_instruction, flush) and outputs
//              (rpl_instruction, vld_out, full, empty, count, dup_done,
//              overflow_err, underrun_err)
module qed_replay_buffer
  import qed_pkg::*;
#(
  parameter int                INSN_W   = 32,
  parameter int                DEPTH    = 16,
  parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(QED_NOP)
) (
  input  logic                clk,
  input  logic                rst,
  qed_replay_buffer_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  qed_state_e       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             vld_out_q, vld_out_d;
  logic             dup_done_q, dup_done_d;
  logic             overflow_err_q, overflow_err_d;
  logic             underrun_err_q, underrun_err_d;

  logic             underrun_edge;
  logic [AW-1:0]    wr_base, rd_base;
  logic [CNT_W-1:0] cnt_base;
  logic             active;
  logic             cap_req, cap_fire, rpl_fire;
  logic [INSN_W-1:0] rd_data;

  always_comb begin
    state_d = bus.exec_dup ? ST_REPLAY : ST_CAPTURE;

    // Leaving the duplicate phase with unreplayed entries discards them.
    // A capture on that same cycle lands in a freshly emptied buffer.
    underrun_edge = (state_q == ST_REPLAY) && !bus.exec_dup && (count_q != '0);
    wr_base  = underrun_edge ? '0 : wr_ptr_q;
    rd_base  = underrun_edge ? '0 : rd_ptr_q;
    cnt_base = underrun_edge ? '0 : count_q;

    active   = bus.ena && !bus.stall_IF && !bus.flush;
    cap_req  = !bus.exec_dup && active && bus.ifu_vld;
    cap_fire = cap_req && (cnt_base != CNT_W'(DEPTH));
    rpl_fire = bus.exec_dup && active && (count_q != '0);

    wr_ptr_d       = wr_base;
    rd_ptr_d       = rd_base;
    count_d        = cnt_base;
    vld_out_d      = vld_out_q;
    dup_done_d     = dup_done_q;
    overflow_err_d = overflow_err_q;
    underrun_err_d = underrun_err_q | underrun_edge;

    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      vld_out_d  = 1'b0;
      dup_done_d = 1'b0;
    end else begin
      if (cap_fire) begin
        wr_ptr_d = wr_base + AW'(1);
        count_d  = cnt_base + CNT_W'(1);
      end else if (cap_req) begin
        overflow_err_d = 1'b1;
      end

      if (rpl_fire) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        count_d   = count_q - CNT_W'(1);
        vld_out_d = 1'b1;
      end else if (!bus.ena || !bus.stall_IF) begin
        // Stall holds the current replay output; anything else idles it.
        vld_out_d = 1'b0;
      end

      // count_q==0 in REPLAY implies nothing is being read this cycle.
      if (!bus.exec_dup) begin
        dup_done_d = 1'b0;
      end else if ((state_q == ST_REPLAY) && (count_q == '0)) begin
        dup_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_CAPTURE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      vld_out_q      <= 1'b0;
      dup_done_q     <= 1'b0;
      overflow_err_q <= 1'b0;
      underrun_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      vld_out_q      <= vld_out_d;
      dup_done_q     <= dup_done_d;
      overflow_err_q <= overflow_err_d;
      underrun_err_q <= underrun_err_d;
    end
  end

  qed_replay_mem #(
    .INSN_W (INSN_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (cap_fire),
    .wr_addr (wr_base),
    .wr_data (bus.ifu_instruction),
    .rd_en   (rpl_fire),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // The read register keeps the last replayed word, so gating it with the
  // valid flag gives both "hold under stall" and "NOP when idle / reset".
  assign bus.rpl_instruction = vld_out_q ? rd_data : NOP_INSN;
  assign bus.vld_out         = vld_out_q;
  assign bus.full            = (count_q == CNT_W'(DEPTH));
  assign bus.empty           = (count_q == '0);
  assign bus.count           = count_q;
  assign bus.dup_done        = dup_done_q;
  assign bus.overflow_err    = overflow_err_q;
  assign bus.underrun_err    = underrun_err_q;

endmodule

// File: tb/tb_qed_replay_buffer.sv
module tb_qed_replay_buffer;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst;

  qed_replay_buffer_if #(.INSN_W(32), .DEPTH(DEPTH)) bus ();

  qed_replay_buffer #(.INSN_W(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is simply a FIFO of captured instructions.
  logic [31:0] exp_q[$];
  bit          exp_ovf = 0;
  bit          exp_und = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ena             = 1'b1;
    bus.exec_dup        = 1'b0;
    bus.stall_IF        = 1'b0;
    bus.ifu_vld         = 1'b0;
    bus.ifu_instruction = '0;
    bus.flush           = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    checks++;
    if (bus.vld_out !== 1'b0 || bus.rpl_instruction !== NOP || bus.count !== '0 ||
        bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.dup_done !== 1'b0 ||
        bus.overflow_err !== 1'b0 || bus.underrun_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: vld=%b rpl=%h cnt=%0d empty=%b full=%b done=%b ovf=%b und=%b required vld=0 rpl=%h cnt=0 empty=1 full=0 done=0 ovf=0 und=0",
               bus.vld_out, bus.rpl_instruction, bus.count, bus.empty, bus.full,
               bus.dup_done, bus.overflow_err, bus.underrun_err, NOP);
    end
    $display("reset: vld=%b rpl=%h cnt=%0d", bus.vld_out, bus.rpl_instruction, bus.count);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Capture n fetched instructions (random stalls); excess beyond DEPTH is dropped.
  task automatic capture_n(input string name, input int n, input int stall_pct);
    int done_n = 0;
    for (int c = 0; c < 4 * n + 10 && done_n < n; c++) begin
      logic [31:0] v;
      v = $urandom;
      bus.exec_dup        = 1'b0;
      bus.ifu_vld         = 1'b1;
      bus.ifu_instruction = v;
      bus.stall_IF        = ($urandom_range(0, 99) < stall_pct);
      if (!bus.stall_IF) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
        else exp_ovf = 1;
        done_n++;
      end
      tick();
      checks++;
      if (bus.count !== exp_q.size() || bus.full !== (exp_q.size() == DEPTH) ||
          bus.empty !== (exp_q.size() == 0) || bus.overflow_err !== exp_ovf ||
          bus.underrun_err !== exp_und) begin
        errors++;
        $display("FAIL %s_capture: cnt=%0d full=%b empty=%b ovf=%b und=%b required cnt=%0d full=%b empty=%b ovf=%b und=%b",
                 name, bus.count, bus.full, bus.empty, bus.overflow_err, bus.underrun_err,
                 exp_q.size(), exp_q.size() == DEPTH, exp_q.size() == 0, exp_ovf, exp_und);
      end
      $display("%s cap: data=%h stall=%b cnt=%0d", name, v, bus.stall_IF, bus.count);
    end
    bus.ifu_vld  = 1'b0;
    bus.stall_IF = 1'b0;
  endtask

  // Replay until drained; stall_mask forces stalls on given cycles.
  task automatic run_replay(input string name, input int stall_pct, input logic [31:0] stall_mask);
    bit          ev = 0;
    logic [31:0] er = NOP;
    bit          drained = 0;
    bus.exec_dup = 1'b1;
    bus.ifu_vld  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.stall_IF = (c < 32 && stall_mask[c]) || ($urandom_range(0, 99) < stall_pct);
      if (!bus.stall_IF) begin
        if (exp_q.size() > 0) begin
          ev = 1;
          er = exp_q.pop_front();
        end else begin
          ev = 0;
          er = NOP;
        end
      end
      tick();
      checks++;
      if (bus.vld_out !== ev || bus.rpl_instruction !== er || bus.count !== exp_q.size()) begin
        errors++;
        $display("FAIL %s_replay: vld=%b rpl=%h cnt=%0d required vld=%b rpl=%h cnt=%0d",
                 name, bus.vld_out, bus.rpl_instruction, bus.count, ev, er, exp_q.size());
      end
      $display("%s rpl: stall=%b vld=%b rpl=%h cnt=%0d", name, bus.stall_IF,
               bus.vld_out, bus.rpl_instruction, bus.count);
      if (!bus.stall_IF && !ev) begin
        drained = 1;
        break;
      end
    end
    checks++;
    if (!drained || bus.dup_done !== 1'b1 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: drained=%b dup_done=%b empty=%b required drained=1 dup_done=1 empty=1",
               name, drained, bus.dup_done, bus.empty);
    end
    bus.stall_IF = 1'b0;
    bus.exec_dup = 1'b0;
    tick();
    checks++;
    if (bus.dup_done !== 1'b0 || bus.vld_out !== 1'b0 || bus.underrun_err !== exp_und) begin
      errors++;
      $display("FAIL %s_exit: dup_done=%b vld=%b und=%b required dup_done=0 vld=0 und=%b",
               name, bus.dup_done, bus.vld_out, bus.underrun_err, exp_und);
    end
  endtask

  task automatic test_basic();
    capture_n("basic", 3, 0);
    run_replay("basic", 0, 32'h0);
  endtask

  task automatic test_overflow();
    capture_n("ovf", 17, 20);
    run_replay("ovf", 0, 32'h0);
  endtask

  task automatic test_stall();
    capture_n("stall", 3, 0);
    run_replay("stall", 0, 32'b0110);
    capture_n("rstall", 12, 30);
    run_replay("rstall", 30, 32'h0);
  endtask

  task automatic test_wrap();
    capture_n("wrap1", 10, 0);
    run_replay("wrap1", 0, 32'h0);
    capture_n("wrap2", 10, 10);
    run_replay("wrap2", 10, 32'h0);
  endtask

  task automatic test_ena_freeze();
    capture_n("ena", 3, 0);
    bus.ena     = 1'b0;
    bus.ifu_vld = 1'b1;
    bus.ifu_instruction = $urandom;
    tick();
    bus.ifu_vld  = 1'b0;
    bus.exec_dup = 1'b1;
    tick();
    checks++;
    if (bus.count !== exp_q.size() || bus.vld_out !== 1'b0 || bus.rpl_instruction !== NOP) begin
      errors++;
      $display("FAIL ena_freeze: cnt=%0d vld=%b rpl=%h required cnt=%0d vld=0 rpl=%h",
               bus.count, bus.vld_out, bus.rpl_instruction, exp_q.size(), NOP);
    end
    $display("ena freeze: cnt=%0d vld=%b", bus.count, bus.vld_out);
    bus.ena = 1'b1;
    run_replay("ena", 0, 32'h0);
  endtask

  task automatic test_underrun_flush();
    capture_n("und", 5, 0);
    bus.exec_dup = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      tick();
      checks++;
      if (bus.vld_out !== 1'b1 || bus.rpl_instruction !== e) begin
        errors++;
        $display("FAIL und_partial: vld=%b rpl=%h required vld=1 rpl=%h", bus.vld_out, bus.rpl_instruction, e);
      end
    end
    bus.exec_dup = 1'b0;
    exp_q.delete();
    exp_und = 1;
    tick();
    checks++;
    if (bus.underrun_err !== 1'b1 || bus.count !== '0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL underrun: und=%b cnt=%0d empty=%b required und=1 cnt=0 empty=1",
               bus.underrun_err, bus.count, bus.empty);
    end
    $display("underrun: und=%b cnt=%0d", bus.underrun_err, bus.count);
    capture_n("flush", 4, 0);
    bus.flush   = 1'b1;
    bus.ifu_vld = 1'b1;
    bus.ifu_instruction = $urandom;
    tick();
    exp_q.delete();
    checks++;
    if (bus.count !== '0 || bus.dup_done !== 1'b0 || bus.vld_out !== 1'b0 ||
        bus.overflow_err !== exp_ovf || bus.underrun_err !== exp_und) begin
      errors++;
      $display("FAIL flush: cnt=%0d done=%b vld=%b ovf=%b und=%b required cnt=0 done=0 vld=0 ovf=%b und=%b",
               bus.count, bus.dup_done, bus.vld_out, bus.overflow_err, bus.underrun_err, exp_ovf, exp_und);
    end
    $display("flush: cnt=%0d ovf=%b und=%b", bus.count, bus.overflow_err, bus.underrun_err);
    bus.flush   = 1'b0;
    bus.ifu_vld = 1'b0;
    capture_n("postflush", 2, 0);
    run_replay("postflush", 0, 32'h0);
  endtask

  task automatic test_mid_reset();
    capture_n("midrst", 10, 0);
    bus.exec_dup = 1'b1;
    for (int i = 0; i < 4; i++) begin
      void'(exp_q.pop_front());
      tick();
    end
    checks++;
    if (bus.count !== 6 || bus.vld_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: cnt=%0d vld=%b required cnt=6 vld=1", bus.count, bus.vld_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.vld_out !== 1'b0 || bus.count !== '0 || bus.rpl_instruction !== NOP ||
        bus.overflow_err !== 1'b0 || bus.underrun_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst: vld=%b cnt=%0d rpl=%h ovf=%b und=%b required vld=0 cnt=0 rpl=%h ovf=0 und=0",
               bus.vld_out, bus.count, bus.rpl_instruction, bus.overflow_err, bus.underrun_err, NOP);
    end
    $display("mid reset: vld=%b cnt=%0d rpl=%h", bus.vld_out, bus.count, bus.rpl_instruction);
    exp_q.delete();
    exp_ovf = 0;
    exp_und = 0;
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    capture_n("afterrst", 4, 0);
    run_replay("afterrst", 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_wrap();
    test_ena_freeze();
    test_underrun_flush();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
